// File: rtl/mux_stream_8to1_pkg.sv
// Shared constants for the 8-way routing fabric; the demux blocks import the
// same package so that o_sel and the demux sel use one encoding.
package mux_stream_8to1_pkg;

    localparam int NUM_CH        = 8;
    localparam int SEL_W         = 3;
    localparam int DEFAULT_WIDTH = 32;

    // Pointer starts on the last channel so channel 0 is searched first.
    localparam logic [SEL_W-1:0] RR_RESET_PTR = 3'd7;

endpackage

// File: rtl/mux_stream_8to1_rr_arb_8.sv
// Combinational round-robin arbiter for eight requesters. It searches upward
// from last+1 with wrap. The pointer register lives in the parent.
module rr_arb_8
    import mux_stream_8to1_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    input  logic              en,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        if (en) begin
            // Offset 8 lands back on 'last', so it has the lowest priority.
            for (int off = 1; off <= NUM_CH; off++) begin
                cand = last + SEL_W'(off);
                if (!gnt_any && req[cand]) begin
                    gnt_idx = cand;
                    gnt_any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_stream_8to1.sv
// Merges eight valid/ready channels onto one registered output stream. It uses
// round-robin arbitration and tags each beat with its source channel index.
module mux_stream_8to1
    import mux_stream_8to1_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH,
    parameter int snum  = SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [width-1:0]  i0,
    input  logic [width-1:0]  i1,
    input  logic [width-1:0]  i2,
    input  logic [width-1:0]  i3,
    input  logic [width-1:0]  i4,
    input  logic [width-1:0]  i5,
    input  logic [width-1:0]  i6,
    input  logic [width-1:0]  i7,
    input  logic [NUM_CH-1:0] i_valid,
    output logic [NUM_CH-1:0] i_ready,
    output logic [width-1:0]  o,
    output logic [snum-1:0]   o_sel,
    output logic              o_valid,
    input  logic              o_ready
);

    logic [width-1:0] chan [NUM_CH];
    logic             load_en;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_any;
    logic [width-1:0] data_p1;
    logic [snum-1:0]  sel_p1;
    logic             vld_p1;
    logic [SEL_W-1:0] last_p1;

    assign chan[0] = i0;
    assign chan[1] = i1;
    assign chan[2] = i2;
    assign chan[3] = i3;
    assign chan[4] = i4;
    assign chan[5] = i5;
    assign chan[6] = i6;
    assign chan[7] = i7;

    assign load_en = !vld_p1 || o_ready;

    // Gating the enable with rst_n keeps i_ready low for the whole reset.
    rr_arb_8 u_arb (
        .req     (i_valid),
        .last    (last_p1),
        .en      (load_en && rst_n),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign i_ready = gnt_any ? ({{(NUM_CH-1){1'b0}}, 1'b1} << gnt_idx) : '0;

    // Stage p1: output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1 <= '0;
            sel_p1  <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= RR_RESET_PTR;
        end else if (load_en) begin
            if (gnt_any) begin
                data_p1 <= chan[gnt_idx];
                sel_p1  <= gnt_idx;
                vld_p1  <= 1'b1;
                last_p1 <= gnt_idx;
            end else begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign o       = data_p1;
    assign o_sel   = sel_p1;
    assign o_valid = vld_p1;

endmodule

// File: tb/tb_mux_stream_8to1.sv
// Testbench for mux_stream_8to1. A reference model checks every cycle, and
// directed scenarios check hand-computed values.
module tb_mux_stream_8to1;

    logic        clk;
    logic        rst_n;
    logic [31:0] din [8];
    logic [7:0]  i_valid;
    logic [7:0]  i_ready;
    logic [31:0] o;
    logic [2:0]  o_sel;
    logic        o_valid;
    logic        o_ready;

    int tests;
    int fails;

    mux_stream_8to1 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i0      (din[0]),
        .i1      (din[1]),
        .i2      (din[2]),
        .i3      (din[3]),
        .i4      (din[4]),
        .i5      (din[5]),
        .i6      (din[6]),
        .i7      (din[7]),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o       (o),
        .o_sel   (o_sel),
        .o_valid (o_valid),
        .o_ready (o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the winner is the valid channel with the smallest
    // forward distance from the previous grant.
    logic [31:0] m_o;
    logic [2:0]  m_sel;
    logic [2:0]  m_last;
    logic        m_valid;

    function automatic int pick(input logic [7:0] v, input logic [2:0] last);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = 99;
        for (int k = 0; k < 8; k++) begin
            d = (k - int'(last) - 1 + 16) % 8;
            if (v[k] && d < bestd) begin
                best  = k;
                bestd = d;
            end
        end
        return best;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_o = 32'd0; m_sel = 3'd0; m_valid = 1'b0; m_last = 3'd7;
        end else if (!m_valid || o_ready) begin
            g = pick(i_valid, m_last);
            if (g >= 0) begin
                m_o = din[g]; m_sel = 3'(g); m_valid = 1'b1; m_last = 3'(g);
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_rdy;
        int g;
        exp_rdy = 8'd0;
        g = pick(i_valid, m_last);
        if (rst_n && (!m_valid || o_ready) && g >= 0) exp_rdy = 8'd1 << g;
        tests++;
        if (i_ready !== exp_rdy || o_valid !== m_valid || o !== m_o || o_sel !== m_sel) begin
            fails++;
            $display("FAIL model t=%0t: rdy=%h/%h vld=%b/%b o=%h/%h sel=%0d/%0d (dut/exp)",
                     $time, i_ready, exp_rdy, o_valid, m_valid, o, m_o, o_sel, m_sel);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        o_ready = 1'b1;
        i_valid = 8'hFF;
        for (int k = 0; k < 8; k++) din[k] = 32'h1000_0000 + k;
        #3;
        check("reset_ready", 32'(i_ready), 32'h0);
        check("reset_valid", 32'(o_valid), 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("first_ready_ch0", 32'(i_ready), 32'h01);

        // Full contention: grants rotate 0..7 twice with no bubbles.
        for (int n = 0; n < 16; n++) begin
            tick();
            check("rr_sel", 32'(o_sel), 32'(n % 8));
            check("rr_data", o, 32'h1000_0000 + (n % 8));
            check("rr_valid", 32'(o_valid), 32'h1);
        end

        // Reset while a beat is held on the output.
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(o_valid), 32'h0);
        check("midrst_o", o, 32'h0);
        check("midrst_sel", 32'(o_sel), 32'h0);
        check("midrst_ready", 32'(i_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ch0", 32'(o_sel), 32'h0);

        // Idle drain: the pointer stays on channel 0, so channel 1 is next.
        i_valid = 8'h00;
        tick();
        check("drain_valid", 32'(o_valid), 32'h0);
        i_valid = 8'hFF;
        #1;
        check("drain_ptr_kept", 32'(i_ready), 32'h02);
        i_valid = 8'h00;
        tick();

        // Single channel granted on every cycle.
        din[4] = 32'hDEAD_BEEF;
        i_valid = 8'h10;
        #1;
        check("single_ready", 32'(i_ready), 32'h10);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("single_o", o, 32'hDEAD_BEEF);
            check("single_sel", 32'(o_sel), 32'h4);
            check("single_ready_cont", 32'(i_ready), 32'h10);
        end

        // Back-pressure with channel 2 held on the output.
        din[2] = 32'hCAFE_0002;
        i_valid = 8'h04;
        tick();
        o_ready = 1'b0;
        i_valid = 8'hFF;
        for (int n = 0; n < 5; n++) begin
            #1;
            check("stall_ready", 32'(i_ready), 32'h0);
            check("stall_sel", 32'(o_sel), 32'h2);
            check("stall_o", o, 32'hCAFE_0002);
            tick();
        end
        o_ready = 1'b1;
        #1;
        check("release_ready_ch3", 32'(i_ready), 32'h08);
        tick();
        check("release_sel", 32'(o_sel), 32'h3);

        // Wrap and skip: set last to 6, then only channels 0 and 1 request.
        i_valid = 8'h40;
        tick();
        check("wrap_set6", 32'(o_sel), 32'h6);
        i_valid = 8'h03;
        tick();
        check("wrap_g0", 32'(o_sel), 32'h0);
        tick();
        check("wrap_g1", 32'(o_sel), 32'h1);
        tick();
        check("wrap_g0b", 32'(o_sel), 32'h0);

        i_valid = 8'h00;
        tick(); tick();
        check("end_idle", 32'(o_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
